// File: rtl/m216a_pe_pkg.sv
// Shared opcodes, FSM states and the per-function latency table for the M216A streaming PE.
// The PE_SAT_EN build option is consumed by m216a_pe_stream, not by this package.
package m216a_pe_pkg;

   localparam int MAX_LAT = 6;
   localparam int OP_W    = 4;

   localparam logic [OP_W-1:0] FN_PASS2 = 4'd1;
   localparam logic [OP_W-1:0] FN_PASS4 = 4'd2;
   localparam logic [OP_W-1:0] FN_ADD   = 4'd3;
   localparam logic [OP_W-1:0] FN_MUL   = 4'd4;
   localparam logic [OP_W-1:0] FN_MAD   = 4'd5;
   localparam logic [OP_W-1:0] FN_SCALE = 4'd6;
   localparam logic [OP_W-1:0] FN_POLY  = 4'd7;
   localparam logic [OP_W-1:0] FN_MACC  = 4'd8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CLEAR = 2'd2
   } pe_state_e;

   function automatic logic [2:0] fn_latency(input logic [OP_W-1:0] op);
      case (op)
         FN_PASS4, FN_POLY: fn_latency = 3'd4;
         FN_MACC:           fn_latency = 3'd6;
         default:           fn_latency = 3'd2;
      endcase
   endfunction

endpackage

// File: rtl/m216a_pe_delay.sv
// Valid + data shift line; stage k holds what entered k cycles ago.
// The top taps the stage that matches the active function's latency.
module m216a_pe_delay
   import m216a_pe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DEPTH = MAX_LAT - 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   input  logic [WIDTH-1:0]            in_data,
   output logic [DEPTH-1:0]            valid_line,
   output logic [DEPTH-1:0][WIDTH-1:0] data_line
);

   // Shift valid and data one stage per cycle; bubbles travel with Out_Valid=0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_line <= {DEPTH{1'b0}};
         data_line  <= {(DEPTH*WIDTH){1'b0}};
      end else begin
         valid_line <= {valid_line[DEPTH-2:0], in_valid};
         data_line  <= {data_line[DEPTH-2:0], in_data};
      end
   end

endmodule

// File: rtl/m216a_pe_stream.sv
// Valid/ready streamed 8-function processing element with drain/clear on opcode change.
// Build option PE_SAT_EN: results and accumulator clamp to all-ones instead of wrapping.
module m216a_pe_stream
   import m216a_pe_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int INSTR_W = 16,
   parameter int SCALE_K = 7
) (
   input  logic               Clk_In,
   input  logic               Rst_In,
   input  logic [INSTR_W-1:0] Instruction_In,
   input  logic [WIDTH-1:0]   D_In1,
   input  logic [WIDTH-1:0]   D_In2,
   input  logic [WIDTH-1:0]   D_In3,
   input  logic               In_Valid,
   output logic               In_Ready,
   output logic [WIDTH-1:0]   D_Out,
   output logic               Out_Valid
);

   localparam int EXT_W = 2*WIDTH + 2;
   localparam int DEPTH = MAX_LAT - 1;
   localparam logic [EXT_W-1:0] K_X = EXT_W'(SCALE_K);

   pe_state_e              state_r, state_nx_s;
   logic [OP_W-1:0]        opcode_s, cur_fn_r;
   logic [WIDTH-1:0]       h1_r, h2_r, acc_r;
   logic [WIDTH-1:0]       acc_nx_s, result_s;
   logic                   in_ready_s, clear_s, accept_s, line_empty_s;
   logic [EXT_W-1:0]       a_x_s, b_x_s, c_x_s, h1_x_s, h2_x_s, acc_x_s;
   logic [DEPTH-1:0]             valid_line_s;
   logic [DEPTH-1:0][WIDTH-1:0]  data_line_s;
   logic [2:0]             tap_idx_s;
   logic                   tap_valid_s;
   logic [WIDTH-1:0]       tap_data_s;
   logic                   unused_instr_s;

   function automatic logic [WIDTH-1:0] fit(input logic [EXT_W-1:0] v);
`ifdef PE_SAT_EN
      if (|v[EXT_W-1:WIDTH]) begin
         fit = {WIDTH{1'b1}};
      end else begin
         fit = v[WIDTH-1:0];
      end
`else
      fit = v[WIDTH-1:0];
`endif
   endfunction

   assign opcode_s       = Instruction_In[OP_W-1:0];
   assign unused_instr_s = ^Instruction_In[INSTR_W-1:OP_W];

   assign a_x_s   = EXT_W'(D_In1);
   assign b_x_s   = EXT_W'(D_In2);
   assign c_x_s   = EXT_W'(D_In3);
   assign h1_x_s  = EXT_W'(h1_r);
   assign h2_x_s  = EXT_W'(h2_r);
   assign acc_x_s = EXT_W'(acc_r);

   // FSM state register.
   always_ff @(posedge Clk_In or negedge Rst_In) begin
      if (!Rst_In) begin
         state_r <= RUN;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state: an opcode mismatch stops intake until the line is empty.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         RUN: begin
            if (In_Valid && (opcode_s != cur_fn_r)) begin
               state_nx_s = DRAIN;
            end else begin
               state_nx_s = RUN;
            end
         end
         DRAIN: begin
            if (line_empty_s) begin
               state_nx_s = CLEAR;
            end else begin
               state_nx_s = DRAIN;
            end
         end
         CLEAR:   state_nx_s = RUN;
         default: state_nx_s = RUN;
      endcase
   end

   // FSM outputs.
   always_comb begin
      in_ready_s = 1'b0;
      clear_s    = 1'b0;
      case (state_r)
         RUN:     in_ready_s = !(In_Valid && (opcode_s != cur_fn_r));
         DRAIN:   in_ready_s = 1'b0;
         CLEAR:   clear_s    = 1'b1;
         default: in_ready_s = 1'b0;
      endcase
   end

   assign In_Ready = in_ready_s;
   assign accept_s = In_Valid & in_ready_s;

   // Per-function arithmetic; everything widened first, narrowed only at the end.
   always_comb begin
      acc_nx_s = acc_r;
      result_s = {WIDTH{1'b0}};
      case (cur_fn_r)
         FN_PASS2, FN_PASS4: result_s = fit(a_x_s);
         FN_ADD:             result_s = fit(b_x_s + c_x_s);
         FN_MUL:             result_s = fit(a_x_s * b_x_s);
         FN_MAD:             result_s = fit(a_x_s + b_x_s * c_x_s);
         FN_SCALE: begin
            acc_nx_s = fit(acc_x_s + c_x_s * K_X);
            result_s = acc_nx_s;
         end
         FN_POLY:            result_s = fit(h2_x_s * h1_x_s + a_x_s);
         FN_MACC: begin
            acc_nx_s = fit(acc_x_s + h1_x_s * a_x_s);
            result_s = acc_nx_s;
         end
         default:            result_s = {WIDTH{1'b0}};
      endcase
   end

   // Active function, history and accumulator; CLEAR wipes state and adopts the new opcode.
   always_ff @(posedge Clk_In or negedge Rst_In) begin
      if (!Rst_In) begin
         cur_fn_r <= {OP_W{1'b0}};
         h1_r     <= {WIDTH{1'b0}};
         h2_r     <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
      end else if (clear_s) begin
         cur_fn_r <= opcode_s;
         h1_r     <= {WIDTH{1'b0}};
         h2_r     <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         h2_r     <= h1_r;
         h1_r     <= D_In1;
         acc_r    <= acc_nx_s;
      end
   end

   m216a_pe_delay #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_delay (
      .clk        (Clk_In),
      .rst_n      (Rst_In),
      .in_valid   (accept_s),
      .in_data    (result_s),
      .valid_line (valid_line_s),
      .data_line  (data_line_s)
   );

   // Result is computed at accept, so the output register needs stage L-1 (index L-2).
   assign tap_idx_s    = fn_latency(cur_fn_r) - 3'd2;
   assign tap_valid_s  = valid_line_s[tap_idx_s];
   assign tap_data_s   = data_line_s[tap_idx_s];
   assign line_empty_s = ~|valid_line_s;

   // Output register: one-cycle valid pulse, data held between pulses.
   always_ff @(posedge Clk_In or negedge Rst_In) begin
      if (!Rst_In) begin
         Out_Valid <= 1'b0;
         D_Out     <= {WIDTH{1'b0}};
      end else begin
         Out_Valid <= tap_valid_s;
         if (tap_valid_s) begin
            D_Out <= tap_data_s;
         end
      end
   end

endmodule
